// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM defaults (WIDTH, CNT_MAX) and the capture FSM state type
package pwm_pkg;
  localparam int WIDTH = 16;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_e;
endpackage

// File: rtl/pwm_capture_if.sv
// pwm_capture_if: capture bus; slave modport takes pwm_in and drives duty, period, valid, stuck; master is the mirror
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = pwm_pkg::WIDTH
);
  logic pwm_in;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] period;
  logic valid;
  logic stuck;
  modport master (output pwm_in, input duty, period, valid, stuck);
  modport slave (input pwm_in, output duty, period, valid, stuck);
endinterface

// File: rtl/pwm_capture_sync_edge.sv
// sync_edge: SYNC_STAGES synchronizer plus delay flop; ports clk, rst_n, d_i -> lvl_o, rise_o, fall_o
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic lvl_d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q  <= '0;
      lvl_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      lvl_d_q <= sync_q[SYNC_STAGES-1];
    end
  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = lvl_o & ~lvl_d_q;
  assign fall_o = ~lvl_o & lvl_d_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures pwm_in high time and period in clk cycles; ports clk, rst_n, bus (slave: pwm_in -> duty, period, valid, stuck)
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = pwm_pkg::WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  pwm_capture_if.slave bus
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] per_q, per_d, hi_q, hi_d, duty_q, duty_d, period_q, period_d, per_inc, hi_inc;
  logic valid_q, valid_d, stuck_q, stuck_d, lvl, rise, fall;
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .d_i(bus.pwm_in),
    .lvl_o(lvl),
    .rise_o(rise),
    .fall_o(fall)
  );
  assign per_inc = &per_q ? per_q : per_q + 1'b1;
  assign hi_inc  = &hi_q ? hi_q : hi_q + 1'b1;
  always_comb begin
    state_d  = state_q;
    per_d    = per_inc;
    hi_d     = lvl ? hi_inc : hi_q;
    duty_d   = duty_q;
    period_d = period_q;
    stuck_d  = stuck_q;
    valid_d  = 1'b0;
    if (rise && state_q != MEAS_HIGH) begin
      per_d   = WIDTH'(1);
      hi_d    = WIDTH'(1);
      state_d = MEAS_HIGH;
      if (state_q == MEAS_LOW) begin
        period_d = per_q;
        duty_d   = hi_q;
        stuck_d  = 1'b0;
        valid_d  = 1'b1;
      end
    end else if (state_q == WAIT_RISE) begin
      per_d = per_q;
      hi_d  = hi_q;
    end else if (&per_q) begin
      period_d = '1;
      duty_d   = hi_q;
      stuck_d  = 1'b1;
      valid_d  = 1'b1;
      state_d  = WAIT_RISE;
    end else if (fall) begin
      state_d = MEAS_LOW;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= WAIT_RISE;
      per_q    <= '0;
      hi_q     <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  assign bus.duty   = duty_q;
  assign bus.period = period_q;
  assign bus.valid  = valid_q;
  assign bus.stuck  = stuck_q;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: vector table, corner sequences and random periods checked cycle by cycle against an edge-timestamp model
module tb_pwm_capture;
  localparam int W = 12;
  localparam int S = 2;
  localparam int MAXI = (1 << W) - 1;
  localparam logic [W-1:0] MAX = '1;
  typedef struct {
    int hi;
    int lo;
    int reps;
    logic [W-1:0] duty;
    logic [W-1:0] period;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0, vcount = 0, v0, n;
  logic [W-1:0] last_duty, last_period;
  logic last_stuck;
  bit stuck_seen;
  logic [S:0] hist;
  int k, k_r, k_f;
  bit active, fell;
  logic e_valid, e_stuck;
  logic [W-1:0] e_duty, e_period;
  vec_t tbl[6];
  pwm_capture_if #(.WIDTH(W)) b ();
  pwm_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic drive(input int h, input int l, input int reps);
    for (int i = 0; i < reps; i++) begin
      for (int j = 0; j < h; j++) begin @(negedge clk); b.pwm_in = 1'b1; end
      for (int j = 0; j < l; j++) begin @(negedge clk); b.pwm_in = 1'b0; end
    end
    @(posedge clk);
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hist = '0; k = 0; k_r = 0; k_f = 0; active = 0; fell = 0;
      e_valid = 0; e_stuck = 0; e_duty = '0; e_period = '0;
    end else begin
      bit rise, fall;
      rise = hist[S-1] & ~hist[S];
      fall = ~hist[S-1] & hist[S];
      k++;
      e_valid = 0;
      if (rise && active) begin
        e_valid = 1; e_stuck = 0; e_period = W'(k - k_r); e_duty = W'(k_f - k_r);
        k_r = k; fell = 0;
      end else if (rise) begin
        active = 1; k_r = k; fell = 0;
      end else if (active && k - k_r >= MAXI) begin
        e_valid = 1; e_stuck = 1; e_period = MAX; e_duty = fell ? W'(k_f - k_r) : MAX;
        active = 0;
      end else if (fall && active && !fell) begin
        fell = 1; k_f = k;
      end
      hist = {hist[S-1:0], b.pwm_in};
    end
  always @(negedge clk) begin
    check("cycle", 64'({b.valid, b.stuck, b.duty, b.period}), 64'({e_valid, e_stuck, e_duty, e_period}));
    if (b.valid) begin
      vcount++;
      last_duty = b.duty;
      last_period = b.period;
      last_stuck = b.stuck;
      stuck_seen |= b.stuck;
    end
  end
  initial begin
    tbl[0] = '{3, 5, 6, W'(3), W'(8)};
    tbl[1] = '{2, 1, 8, W'(2), W'(3)};
    tbl[2] = '{1, 1, 8, W'(1), W'(2)};
    tbl[3] = '{7, 2, 5, W'(7), W'(9)};
    tbl[4] = '{100, 37, 4, W'(100), W'(137)};
    tbl[5] = '{750, 3345, 4, W'(750), W'(4095)};
    b.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", 64'({b.valid, b.stuck, b.duty, b.period}), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].hi, tbl[i].lo, tbl[i].reps);
      v0 = vcount;
      drive(tbl[i].hi, tbl[i].lo, 2);
      check($sformatf("strobes_%0d", i), 64'(vcount - v0), 64'(2));
      check($sformatf("report_%0d", i), 64'({last_stuck, last_duty, last_period}), 64'({1'b0, tbl[i].duty, tbl[i].period}));
    end
    drive(0, 10, 1);
    v0 = vcount;
    @(negedge clk); b.pwm_in = 1'b1;
    n = 0;
    while (vcount == v0 && n < MAXI + 20) begin @(posedge clk); n++; end
    check("stuck_strobe", 64'(vcount - v0), 64'(1));
    check("stuck_report", 64'({last_stuck, last_duty, last_period}), 64'({1'b1, MAX, MAX}));
    repeat (200) @(posedge clk);
    check("stuck_no_repeat", 64'(vcount - v0), 64'(1));
    drive(0, 6, 1);
    drive(3, 5, 3);
    repeat (6) @(posedge clk);
    check("stuck_cleared", 64'({last_stuck, last_duty, last_period}), 64'({1'b0, W'(3), W'(8)}));
    stuck_seen = 0;
    drive(10, MAXI - 10, 2);
    drive(10, 5, 1);
    check("boundary_no_timeout", 64'(stuck_seen), 64'(0));
    check("boundary_report", 64'({last_stuck, last_duty, last_period}), 64'({1'b0, W'(10), MAX}));
    drive(10, MAXI + 50, 1);
    check("low_timeout", 64'({last_stuck, last_duty, last_period}), 64'({1'b1, W'(10), MAX}));
    drive(3, 5, 4);
    drive(3, 2, 1);
    #2 rst_n = 1'b0;
    b.pwm_in = 1'b1;
    v0 = vcount;
    repeat (2) @(negedge clk);
    check("midreset_out", 64'({b.valid, b.stuck, b.duty, b.period}), 64'(0));
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    check("midreset_no_valid", 64'(vcount - v0), 64'(0));
    drive(2, 5, 1);
    drive(3, 5, 3);
    repeat (6) @(posedge clk);
    check("midreset_report", 64'({last_stuck, last_duty, last_period}), 64'({1'b0, W'(3), W'(8)}));
    for (int i = 0; i < 200; i++)
      drive($urandom_range(1, 20), ($urandom_range(0, 9) == 0) ? $urandom_range(1, 300) : $urandom_range(1, 20), 1);
    repeat (10) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
